// File: rtl/crossing_frame_scheduler_if.sv
// rtl/crossing_frame_scheduler_if.sv - camera-side and datapath-side pixel stream bundle
interface crossing_frame_scheduler_if #(
    parameter int W = 8
);
    logic         cam_valid;
    logic         cam_ready;
    logic [W-1:0] cam_data;
    logic         dp_x_valid;
    logic         dp_x_ready;
    logic [W-1:0] dp_x_data;

    modport master (
        input  cam_valid, cam_data, dp_x_ready,
        output cam_ready, dp_x_valid, dp_x_data
    );

    modport slave (
        output cam_valid, cam_data, dp_x_ready,
        input  cam_ready, dp_x_valid, dp_x_data
    );
endinterface

// File: rtl/crossing_frame_scheduler.sv
// rtl/crossing_frame_scheduler.sv - frame gating, round-robin kernel select and debounced crossing flag
// Optional result-wait watchdog: define CROSSING_SCHED_TIMEOUT_EN.
module crossing_frame_scheduler #(
    parameter int IMG_WIDTH      = 320,
    parameter int IMG_HEIGHT     = 240,
    parameter int KERNEL_H       = 3,
    parameter int KERNEL_W       = 3,
    parameter int W              = 8,
    parameter int NUM_KERNELS    = 2,
    parameter int CONFIRM_FRAMES = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT,
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int SW   = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    localparam int RW   = (KERNEL_H > 1) ? $clog2(KERNEL_H) : 1,
    localparam int KW   = (KERNEL_W > 1) ? $clog2(KERNEL_W) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    crossing_frame_scheduler_if.master px,
    output logic signed [W-1:0] dp_kernel [KERNEL_H][KERNEL_W],
    input  logic                dp_detection_valid,
    input  logic                dp_crossing_detected,
    input  logic [CW-1:0]       dp_white_count,
    input  logic                cfg_we,
    input  logic [SW-1:0]       cfg_sel,
    input  logic [RW-1:0]       cfg_row,
    input  logic [KW-1:0]       cfg_col,
    input  logic signed [W-1:0] cfg_data,
    output logic                frame_done,
    output logic [CW-1:0]       last_white_count,
    output logic [SW-1:0]       kernel_idx,
    output logic                crossing_confirmed,
    output logic                timeout_err
);
    localparam int DW = $clog2(CONFIRM_FRAMES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_DECIDE} state_t;

    state_t              state;
    logic [CW-1:0]       pix_cnt;
    logic [DW-1:0]       agree_cnt;
    logic signed [W-1:0] bank [NUM_KERNELS][KERNEL_H][KERNEL_W];
    logic                res_take;
    logic                res_det;
    logic [CW-1:0]       res_wc;

    // Zero-latency pass-through; ready comes only from the datapath, never from cam_valid.
    assign px.cam_ready  = (state == S_STREAM) && px.dp_x_ready;
    assign px.dp_x_valid = (state == S_STREAM) && px.cam_valid;
    assign px.dp_x_data  = (state == S_STREAM) ? px.cam_data : '0;

`ifdef CROSSING_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;
`endif

    always_comb begin
        res_take = 1'b0;
        res_det  = dp_crossing_detected;
        res_wc   = dp_white_count;
`ifdef CROSSING_SCHED_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (state == S_WAIT) begin
            if (dp_detection_valid) begin
                res_take = 1'b1;
            end
`ifdef CROSSING_SCHED_TIMEOUT_EN
            else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                res_take    = 1'b1;
                res_det     = 1'b0;
                res_wc      = '0;
                timeout_hit = 1'b1;
            end
`endif
        end
    end

`ifdef CROSSING_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_KERNELS; s++)
                for (int r = 0; r < KERNEL_H; r++)
                    for (int c = 0; c < KERNEL_W; c++)
                        bank[s][r][c] <= '0;
        end else if (cfg_we && int'(cfg_sel) < NUM_KERNELS &&
                     int'(cfg_row) < KERNEL_H && int'(cfg_col) < KERNEL_W) begin
            bank[cfg_sel][cfg_row][cfg_col] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            pix_cnt            <= '0;
            agree_cnt          <= '0;
            kernel_idx         <= '0;
            frame_done         <= 1'b0;
            last_white_count   <= '0;
            crossing_confirmed <= 1'b0;
            for (int r = 0; r < KERNEL_H; r++)
                for (int c = 0; c < KERNEL_W; c++)
                    dp_kernel[r][c] <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (enable) state <= S_LOAD;
                S_LOAD: begin
                    for (int r = 0; r < KERNEL_H; r++)
                        for (int c = 0; c < KERNEL_W; c++)
                            dp_kernel[r][c] <= bank[kernel_idx][r][c];
                    pix_cnt <= '0;
                    state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (px.cam_valid && px.dp_x_ready) begin
                        pix_cnt <= pix_cnt + CW'(1);
                        if (pix_cnt == CW'(NPIX - 1)) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Result is folded in on entry so frame_done and the flag are visible during DECIDE.
                    if (res_take) begin
                        state            <= S_DECIDE;
                        frame_done       <= 1'b1;
                        last_white_count <= res_wc;
                        if (res_det == crossing_confirmed) begin
                            agree_cnt <= '0;
                        end else if (agree_cnt == DW'(CONFIRM_FRAMES - 1)) begin
                            crossing_confirmed <= ~crossing_confirmed;
                            agree_cnt          <= '0;
                        end else begin
                            agree_cnt <= agree_cnt + DW'(1);
                        end
                    end
                end
                S_DECIDE: begin
                    kernel_idx <= (kernel_idx == SW'(NUM_KERNELS - 1)) ? '0 : kernel_idx + SW'(1);
                    state      <= enable ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crossing_frame_scheduler.sv
// tb/tb_crossing_frame_scheduler.sv - randomized frame scheduler bench against a frame-level model
module tb_crossing_frame_scheduler;
    localparam int NP = 16, KH = 3, KWD = 3, W = 8, NK = 2, CF = 3, TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    crossing_frame_scheduler_if #(.W(W)) px ();
    logic signed [W-1:0] dp_kernel [KH][KWD];
    logic                dp_detection_valid = 1'b0;
    logic                dp_crossing_detected = 1'b0;
    logic [3:0]          dp_white_count = '0;
    logic                cfg_we = 1'b0;
    logic [0:0]          cfg_sel = '0;
    logic [1:0]          cfg_row = '0;
    logic [1:0]          cfg_col = '0;
    logic signed [W-1:0] cfg_data = '0;
    logic                frame_done;
    logic [3:0]          last_white_count;
    logic [0:0]          kernel_idx;
    logic                crossing_confirmed;
    logic                timeout_err;

    crossing_frame_scheduler #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL_H(KH), .KERNEL_W(KWD), .W(W),
        .NUM_KERNELS(NK), .CONFIRM_FRAMES(CF), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .px(px),
        .dp_kernel(dp_kernel), .dp_detection_valid(dp_detection_valid),
        .dp_crossing_detected(dp_crossing_detected), .dp_white_count(dp_white_count),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_row(cfg_row), .cfg_col(cfg_col),
        .cfg_data(cfg_data), .frame_done(frame_done), .last_white_count(last_white_count),
        .kernel_idx(kernel_idx), .crossing_confirmed(crossing_confirmed), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] mbank [NK][KH][KWD];
    logic signed [W-1:0] snap [KH][KWD];
    int frame_no = 0;
    bit m_conf = 1'b0;
    bit m_err = 1'b0;
    bit hist [$];

    function automatic int kmis();
        int n = 0;
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWD; c++)
                if (dp_kernel[r][c] !== snap[r][c]) n++;
        return n;
    endfunction

    // Flag flips once CF consecutive results disagree with it; an agreeing result forgets the run.
    task automatic model_result(input bit r);
        if (r == m_conf) hist.delete();
        else begin
            hist.push_back(r);
            if (hist.size() == CF) begin
                m_conf = ~m_conf;
                hist.delete();
            end
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NK; s++)
            for (int r = 0; r < KH; r++)
                for (int c = 0; c < KWD; c++) mbank[s][r][c] = '0;
        frame_no = 0;
        m_conf = 1'b0;
        m_err = 1'b0;
        hist.delete();
    endtask

    task automatic program_banks();
        logic signed [W-1:0] v;
        for (int s = 0; s < NK; s++)
            for (int r = 0; r < KH; r++)
                for (int c = 0; c < KWD; c++) begin
                    v = W'($urandom);
                    if (s == 1 && r == 1 && c == 1) v = ~mbank[0][1][1];
                    @(negedge clk);
                    cfg_we = 1'b1; cfg_sel = 1'(s); cfg_row = 2'(r); cfg_col = 2'(c); cfg_data = v;
                    mbank[s][r][c] = v;
                end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_frame(input bit det, input logic [3:0] wc, input int delay,
                             input bit rand_valid, input bit en, input bit mid_write);
        int xfers = 0, wait_c = 0, exp_done;
        bit done_seen = 1'b0, wrote = 1'b0, exp_det;
        logic [3:0] exp_wc;
        logic signed [W-1:0] nv;
        enable = en;
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWD; c++) snap[r][c] = mbank[frame_no % NK][r][c];
        exp_done = (delay >= 0) ? delay + 1 : TO + 1;
        exp_det  = (delay >= 0) ? det : 1'b0;
        exp_wc   = (delay >= 0) ? wc : 4'd0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            @(negedge clk);
            px.cam_valid  = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            px.cam_data   = W'($urandom);
            px.dp_x_ready = 1'($urandom_range(0, 1));
            cfg_we = 1'b0;
            if (xfers < NP) begin
                dp_detection_valid   = ($urandom_range(0, 3) == 0);
                dp_crossing_detected = 1'($urandom);
                dp_white_count       = 4'($urandom);
            end else begin
                wait_c++;
                dp_detection_valid   = (wait_c == delay);
                dp_crossing_detected = det;
                dp_white_count       = wc;
            end
            if (mid_write && !wrote && xfers == 5) begin
                nv = mbank[0][2][2] ^ 8'sh3c;
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_row = 2'd2; cfg_col = 2'd2; cfg_data = nv;
                mbank[0][2][2] = nv;
                wrote = 1'b1;
            end
            #1;
            checks++;
            if (px.cam_ready && !px.dp_x_ready) begin
                errors++; $display("FAIL ready_dep cam_ready=%b dp_x_ready=%b", px.cam_ready, px.dp_x_ready);
            end
            if (xfers >= NP) begin
                checks++;
                if (px.cam_ready !== 1'b0 || px.dp_x_valid !== 1'b0) begin
                    errors++; $display("FAIL post_frame_gate frame=%0d cam_ready=%b dp_x_valid=%b want 0 0", frame_no, px.cam_ready, px.dp_x_valid);
                end
            end else if (px.cam_ready) begin
                checks++;
                if (px.dp_x_valid !== px.cam_valid || px.dp_x_data !== px.cam_data) begin
                    errors++; $display("FAIL pass_through valid=%b/%b data=%h/%h", px.dp_x_valid, px.cam_valid, px.dp_x_data, px.cam_data);
                end
                checks++;
                if (kmis() != 0) begin
                    errors++; $display("FAIL kernel frame=%0d mismatching_coefs=%0d want 0 (k00 got %h want %h)", frame_no, kmis(), dp_kernel[0][0], snap[0][0]);
                end
                checks++;
                if (kernel_idx !== 1'(frame_no % NK)) begin
                    errors++; $display("FAIL kernel_idx frame=%0d got %0d want %0d", frame_no, kernel_idx, frame_no % NK);
                end
                if (px.cam_valid) xfers++;
            end
            if (frame_done === 1'b1) begin
                done_seen = 1'b1;
                model_result(exp_det);
                if (delay < 0) m_err = 1'b1;
                checks++;
                if (wait_c != exp_done) begin
                    errors++; $display("FAIL done_timing frame=%0d got cycle %0d after last pixel want %0d (xfers %0d)", frame_no, wait_c, exp_done, xfers);
                end
                checks++;
                if (last_white_count !== exp_wc) begin
                    errors++; $display("FAIL white_count frame=%0d got %0d want %0d", frame_no, last_white_count, exp_wc);
                end
                checks++;
                if (crossing_confirmed !== m_conf) begin
                    errors++; $display("FAIL confirmed frame=%0d got %b want %b", frame_no, crossing_confirmed, m_conf);
                end
                checks++;
                if (timeout_err !== m_err) begin
                    errors++; $display("FAIL timeout_err frame=%0d got %b want %b", frame_no, timeout_err, m_err);
                end
            end
        end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL frame_budget frame=%0d got no frame_done want one (xfers %0d)", frame_no, xfers);
        end
        @(negedge clk);
        dp_detection_valid = 1'b0;
        cfg_we = 1'b0;
        #1;
        checks++;
        if (frame_done !== 1'b0 || px.cam_ready !== 1'b0) begin
            errors++; $display("FAIL after_decide frame=%0d frame_done=%b cam_ready=%b want 0 0", frame_no, frame_done, px.cam_ready);
        end
        checks++;
        if (kernel_idx !== 1'((frame_no + 1) % NK)) begin
            errors++; $display("FAIL kernel_advance frame=%0d got %0d want %0d", frame_no, kernel_idx, (frame_no + 1) % NK);
        end
        frame_no++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        px.cam_valid = 1'b0; px.cam_data = '0; px.dp_x_ready = 1'b0;
        model_reset();
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWD; c++) snap[r][c] = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({px.cam_ready, px.dp_x_valid, frame_done, crossing_confirmed, timeout_err} !== 5'b0 ||
            last_white_count !== 4'd0 || kernel_idx !== 1'b0 || px.dp_x_data !== 8'd0 || kmis() != 0) begin
            errors++; $display("FAIL reset_state ready=%b valid=%b done=%b conf=%b terr=%b wc=%0d idx=%0d kmis=%0d want all 0",
                px.cam_ready, px.dp_x_valid, frame_done, crossing_confirmed, timeout_err, last_white_count, kernel_idx, kmis());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_kernel_round_robin();
        run_frame(1'b1, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
        run_frame(1'b0, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_debounce();
        run_frame(1'b1, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
        checks++;
        if (crossing_confirmed !== 1'b0) begin
            errors++; $display("FAIL confirm_early got %b want 0", crossing_confirmed);
        end
        run_frame(1'b1, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
        checks++;
        if (crossing_confirmed !== 1'b1) begin
            errors++; $display("FAIL confirm_rise got %b want 1", crossing_confirmed);
        end
        for (int i = 0; i < 3; i++) run_frame(1'b0, 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
        checks++;
        if (crossing_confirmed !== 1'b0) begin
            errors++; $display("FAIL confirm_fall got %b want 0", crossing_confirmed);
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 8; i++)
            run_frame(1'($urandom), 4'($urandom), $urandom_range(1, 6), 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_midframe_bank_write();
        if (frame_no % NK != 0) run_frame(1'($urandom), 4'($urandom), 3, 1'b1, 1'b1, 1'b0);
        run_frame(1'($urandom), 4'($urandom), 3, 1'b1, 1'b1, 1'b1);
        run_frame(1'($urandom), 4'($urandom), 3, 1'b1, 1'b1, 1'b0);
        run_frame(1'($urandom), 4'($urandom), 3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_enable_gate();
        run_frame(1'($urandom), 4'($urandom), 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            px.cam_valid = 1'b1; px.dp_x_ready = 1'b1;
            #1;
            checks++;
            if (px.cam_ready !== 1'b0 || px.dp_x_valid !== 1'b0 || frame_done !== 1'b0) begin
                errors++; $display("FAIL idle_gate cam_ready=%b dp_x_valid=%b frame_done=%b want 0 0 0", px.cam_ready, px.dp_x_valid, frame_done);
            end
        end
        run_frame(1'($urandom), 4'($urandom), 4, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_result_wait();
`ifdef CROSSING_SCHED_TIMEOUT_EN
        run_frame(1'b1, 4'd9, -1, 1'b0, 1'b1, 1'b0);
`else
        run_frame(1'($urandom), 4'($urandom), 20, 1'b0, 1'b1, 1'b0);
`endif
        run_frame(1'($urandom), 4'($urandom), 5, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int xfers = 0;
        if (frame_no % NK != 1) run_frame(1'($urandom), 4'($urandom), 3, 1'b0, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 200 && xfers < 7; cyc++) begin
            @(negedge clk);
            px.cam_valid = 1'b1; px.dp_x_ready = 1'($urandom_range(0, 1)); px.cam_data = W'($urandom);
            #1;
            if (px.cam_ready && px.cam_valid) xfers++;
        end
        checks++;
        if (xfers != 7) begin
            errors++; $display("FAIL abort_setup got %0d transfers want 7", xfers);
        end
        px.dp_x_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWD; c++) snap[r][c] = '0;
        checks++;
        if ({px.cam_ready, px.dp_x_valid, frame_done, crossing_confirmed, timeout_err} !== 5'b0 ||
            last_white_count !== 4'd0 || kernel_idx !== 1'b0 || kmis() != 0) begin
            errors++; $display("FAIL abort_reset ready=%b valid=%b done=%b conf=%b terr=%b wc=%0d idx=%0d kmis=%0d want all 0",
                px.cam_ready, px.dp_x_valid, frame_done, crossing_confirmed, timeout_err, last_white_count, kernel_idx, kmis());
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        program_banks();
        run_frame(1'($urandom), 4'($urandom), 5, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        program_banks();
        test_kernel_round_robin();
        test_debounce();
        test_random_frames();
        test_midframe_bank_write();
        test_enable_gate();
        test_result_wait();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/crossing_frame_scheduler.md
# crossing_frame_scheduler

Frame-level controller in front of the `pattern_recognition` edge-filter/zebra-detector datapath. It gates the camera pixel stream into whole frames and selects one of `NUM_KERNELS` programmable edge kernels per frame, round-robin, changing the kernel only between frames. It collects each frame's detection result and turns the per-frame `crossing_detected` pulses into a debounced, hysteretic `crossing_confirmed` flag for the system controller.

## Interface
Parameters:
- `IMG_WIDTH`, 320: pixels per line.
- `IMG_HEIGHT`, 240: lines per frame; frame length `NPIX = IMG_WIDTH*IMG_HEIGHT`.
- `KERNEL_H`, `KERNEL_W`, 3, 3: kernel dimensions.
- `W`, 8: pixel and kernel coefficient width.
- `NUM_KERNELS`, 2: kernel bank depth, ≥1.
- `CONFIRM_FRAMES`, 3: consecutive agreeing frames needed to toggle `crossing_confirmed`, ≥1.
- `TIMEOUT_CYCLES`, 4096: result wait limit (see Configuration).

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run frames when high.
- `cam_valid`  in  1  camera pixel valid.
- `cam_ready`  out  1  camera pixel ready.
- `cam_data`  in  W  camera pixel.
- `dp_x_valid`  out  1  pixel valid to the datapath.
- `dp_x_ready`  in  1  datapath ready.
- `dp_x_data`  out  W  pixel to the datapath.
- `dp_kernel`  out  signed W × [KERNEL_H][KERNEL_W]  active kernel.
- `dp_detection_valid`  in  1  datapath per-frame result strobe.
- `dp_crossing_detected`  in  1  datapath per-frame result.
- `dp_white_count`  in  clog2(NPIX)  datapath white count.
- `cfg_we`  in  1  kernel bank write strobe.
- `cfg_sel`  in  clog2(NUM_KERNELS) (min 1)  bank index.
- `cfg_row`, `cfg_col`  in  clog2(KERNEL_H), clog2(KERNEL_W) (min 1)  coefficient position.
- `cfg_data`  in  signed W  coefficient value.
- `frame_done`  out  1  one-cycle pulse per completed frame.
- `last_white_count`  out  clog2(NPIX)  white count of the last completed frame.
- `kernel_idx`  out  clog2(NUM_KERNELS) (min 1)  kernel used by the current or last frame.
- `crossing_confirmed`  out  1  debounced detection.
- `timeout_err`  out  1  sticky; cleared only by reset.

## Operation
- States: IDLE, LOAD, STREAM, WAIT_RESULT, DECIDE.
- IDLE:
  - `cam_ready` and `dp_x_valid` are 0.
  - Goes to LOAD when `enable` is 1.
- LOAD (1 cycle):
  - Copies bank[`kernel_idx`] into the `dp_kernel` register.
  - Clears the pixel counter; goes to STREAM.
- STREAM:
  - Pass-through: `dp_x_valid`=`cam_valid`, `cam_ready`=`dp_x_ready`, `dp_x_data`=`cam_data`.
  - The counter increments on each `cam_valid&&dp_x_ready`.
  - On the transfer that reaches `NPIX`, goes to WAIT_RESULT.
  - `enable` is sampled only in IDLE and DECIDE; a frame in progress always completes.
- WAIT_RESULT:
  - `cam_ready`=0 and `dp_x_valid`=0.
  - On `dp_detection_valid`, latches `dp_white_count` and `dp_crossing_detected`, then goes to DECIDE.
- DECIDE (1 cycle):
  - Pulses `frame_done` and updates the debouncer.
  - Advances `kernel_idx` modulo `NUM_KERNELS`, wrapping from `NUM_KERNELS-1` to 0.
  - Goes to LOAD if `enable`=1, otherwise IDLE.
- Debouncer:
  - A saturating agree-counter counts consecutive frames whose result differs from `crossing_confirmed`.
  - When it reaches `CONFIRM_FRAMES`, `crossing_confirmed` toggles and the counter clears.
  - A frame that agrees with `crossing_confirmed` clears the counter.
- Kernel bank writes are accepted in any state.
  - A write to the bank entry currently in use does not affect `dp_kernel` until the next LOAD.
- `dp_detection_valid` in any state other than WAIT_RESULT is ignored.

## Timing
- Reset values:
  - state IDLE.
  - All outputs 0.
  - `dp_kernel` all-zero.
  - bank all-zero.
  - `kernel_idx` 0.
- Pixel path is combinational pass-through in STREAM: zero latency, no buffering.
- Pixel handshake follows AXI-stream rules.
  - `cam_ready` never depends combinationally on `cam_valid`.
- Cycles:
  - `enable` rising in IDLE → LOAD next cycle → STREAM the cycle after.
  - `dp_detection_valid` → DECIDE next cycle.
  - `frame_done` and `crossing_confirmed` update in that DECIDE cycle (registered).
- Overhead is 2 cycles per frame (DECIDE + LOAD) plus the datapath result latency.
- Asserting `rst_n` mid-frame aborts immediately.
  - Partial frame and debouncer state are discarded.

## Configuration
- `CROSSING_SCHED_TIMEOUT_EN` defined:
  - A WAIT_RESULT cycle counter runs.
  - After `TIMEOUT_CYCLES` cycles without a result: sets `timeout_err`, treats the frame as not-detected with white count 0, and enters DECIDE.
- Not defined:
  - WAIT_RESULT waits indefinitely.
  - `timeout_err` is tied to 0 and no counter is built.

## Test plan
- 4×4 image, `NUM_KERNELS`=2, distinct kernels written, `enable`=1, result after 5 cycles:
  - `dp_kernel` equals bank0 in frame 1, bank1 in frame 2, bank0 in frame 3.
  - `frame_done` pulses once per frame.
- `dp_x_ready` toggled randomly while `cam_valid` is held high:
  - Exactly 16 transfers per frame.
  - `cam_ready`=0 from the 16th transfer until the next STREAM.
- `CONFIRM_FRAMES`=3, results 1,1,0,1,1,1 → `crossing_confirmed` rises at the 6th DECIDE.
  - Then 0,0,0 → falls at the 3rd DECIDE.
- Write bank0 during STREAM of a frame using bank0:
  - `dp_kernel` unchanged until the next frame that uses bank0.
- With the macro defined and `TIMEOUT_CYCLES`=8, no `dp_detection_valid`:
  - `timeout_err`=1 after 8 cycles in WAIT_RESULT.
  - `last_white_count`=0 and the next frame starts.
- Deassert `rst_n` at pixel 7:
  - All outputs return to 0 immediately.
  - After release with `enable`=1, the next frame uses bank0.
